// File: rtl/result_bus_arbiter_pkg.sv
// Shared types for the CDB result arbiter: condition/exception bundle, CDB entry, CR0 helper.
// The CR0 helper is only used when RESULT_ARB_CR0_CALC_EN is defined.
package result_bus_arbiter_pkg;

    localparam int CDB_RS_ID_WIDTH = 5;

    typedef struct packed {
        logic cr0_valid;
        logic cr0_lt;
        logic cr0_gt;
        logic cr0_eq;
        logic cr0_so;
        logic xer_valid;
        logic xer_so;
        logic xer_ov;
        logic xer_ca;
    } cond_exception_t;

    typedef struct packed {
        logic [CDB_RS_ID_WIDTH-1:0] rs_id;
        logic [4:0]                 reg_addr;
        logic [31:0]                result;
        cond_exception_t            cr0_xer;
    } cdb_entry_t;

    // Replace CR0 with a signed compare of the result against zero; no CR0 update clears the bits.
    function automatic cond_exception_t calc_cr0(input cond_exception_t ce,
                                                 input logic [31:0]     result,
                                                 input logic            so);
        cond_exception_t r;
        r        = ce;
        r.cr0_lt = ce.cr0_valid & result[31];
        r.cr0_gt = ce.cr0_valid & ~result[31] & (|result);
        r.cr0_eq = ce.cr0_valid & (result == 32'd0);
        r.cr0_so = ce.cr0_valid & so;
        return r;
    endfunction

endpackage

// File: rtl/result_bus_arbiter_if.sv
// Bundle of execution-unit result ports and the common data bus.
// slave = arbiter side, master = units/CDB consumer side.
interface result_bus_arbiter_if
    import result_bus_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = CDB_RS_ID_WIDTH
) ();

    logic [0:NUM_UNITS-1]                  unit_valid;
    logic [0:NUM_UNITS-1]                  unit_ready;
    logic [0:NUM_UNITS-1][RS_ID_WIDTH-1:0] unit_rs_id;
    logic [0:NUM_UNITS-1][4:0]             unit_reg_addr;
    logic [0:NUM_UNITS-1][31:0]            unit_result;
    cond_exception_t [0:NUM_UNITS-1]       unit_cr0_xer;
    logic                                  xer_so;

    logic                                  cdb_valid;
    logic                                  cdb_ready;
    logic [RS_ID_WIDTH-1:0]                cdb_rs_id;
    logic [4:0]                            cdb_reg_addr;
    logic [31:0]                           cdb_result;
    cond_exception_t                       cdb_cr0_xer;

    modport slave (
        input  unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, xer_so, cdb_ready,
        output unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer
    );

    modport master (
        output unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, xer_so, cdb_ready,
        input  unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer
    );

endinterface

// File: rtl/result_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// The pointer register lives in the parent.
module result_bus_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [0:NUM_REQ-1] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [0:NUM_REQ-1] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = PTR_W'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter forwarding one execution-unit result per cycle onto the CDB.
// Optional feature macro: RESULT_ARB_CR0_CALC_EN (recompute CR0 from the result at capture).
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = CDB_RS_ID_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    result_bus_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_UNITS);

    // The output register reuses the package entry type, so the tag width is tied to it.
    if (RS_ID_WIDTH != CDB_RS_ID_WIDTH || NUM_UNITS < 2) begin : g_bad_config
        $error("result_bus_arbiter: unsupported NUM_UNITS/RS_ID_WIDTH");
    end

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [0:NUM_UNITS-1] grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 any_req;
    logic                 free;
    logic                 cdb_valid_q;
    cdb_entry_t           entry_q;
    cdb_entry_t           captured;

    result_bus_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_UNITS),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req       (bus.unit_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    assign free     = ~cdb_valid_q | bus.cdb_ready;
    assign ptr_next = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;

    assign bus.unit_ready = (rst || !free) ? '0 : grant;

    always_comb begin
        captured.rs_id    = bus.unit_rs_id[grant_idx];
        captured.reg_addr = bus.unit_reg_addr[grant_idx];
        captured.result   = bus.unit_result[grant_idx];
`ifdef RESULT_ARB_CR0_CALC_EN
        captured.cr0_xer  = calc_cr0(bus.unit_cr0_xer[grant_idx], bus.unit_result[grant_idx], bus.xer_so);
`else
        captured.cr0_xer  = bus.unit_cr0_xer[grant_idx];
`endif
    end

`ifndef RESULT_ARB_CR0_CALC_EN
    logic unused_xer_so;
    assign unused_xer_so = bus.xer_so;
`endif

    // A grant only fires while the register is free, so a new entry may overwrite one being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q     <= '0;
            cdb_valid_q <= 1'b0;
            ptr         <= '0;
        end else if (free) begin
            if (any_req) begin
                entry_q     <= captured;
                cdb_valid_q <= 1'b1;
                ptr         <= ptr_next;
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_rs_id    = entry_q.rs_id;
    assign bus.cdb_reg_addr = entry_q.reg_addr;
    assign bus.cdb_result   = entry_q.result;
    assign bus.cdb_cr0_xer  = entry_q.cr0_xer;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench for result_bus_arbiter: a reference round-robin model queues the
// expected CDB entry on every grant and compares it while it sits on the bus.
`timescale 1ns/1ps
module tb_result_bus_arbiter;
    import result_bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int RW = CDB_RS_ID_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_bus_arbiter_if #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) bus ();

    result_bus_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [0:N-1] req;
    cdb_entry_t   unit_data [N];
    logic         xer_so_v;
    logic         cdb_ready_v;
    bit           one_shot;

    int           m_ptr;
    bit           m_valid;
    cdb_entry_t   sb [$];

    task automatic drive();
        bus.unit_valid = req;
        for (int i = 0; i < N; i++) begin
            bus.unit_rs_id[i]    = unit_data[i].rs_id;
            bus.unit_reg_addr[i] = unit_data[i].reg_addr;
            bus.unit_result[i]   = unit_data[i].result;
            bus.unit_cr0_xer[i]  = unit_data[i].cr0_xer;
        end
        bus.xer_so    = xer_so_v;
        bus.cdb_ready = cdb_ready_v;
    endtask

    function automatic cdb_entry_t rand_entry();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[$bits(cdb_entry_t)-1:0];
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [0:N-1] model_ready();
        logic [0:N-1] r;
        int g;
        r = '0;
        g = model_grant();
        if (!rst && (!m_valid || cdb_ready_v) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic cdb_entry_t model_capture(int u);
        cdb_entry_t e;
        e = unit_data[u];
`ifdef RESULT_ARB_CR0_CALC_EN
        if (e.cr0_xer.cr0_valid) begin
            e.cr0_xer.cr0_lt = e.result[31];
            e.cr0_xer.cr0_gt = !e.result[31] && (e.result != 32'd0);
            e.cr0_xer.cr0_eq = (e.result == 32'd0);
            e.cr0_xer.cr0_so = xer_so_v;
        end else begin
            e.cr0_xer.cr0_lt = 1'b0;
            e.cr0_xer.cr0_gt = 1'b0;
            e.cr0_xer.cr0_eq = 1'b0;
            e.cr0_xer.cr0_so = 1'b0;
        end
`endif
        return e;
    endfunction

    function automatic cdb_entry_t observed();
        cdb_entry_t e;
        e.rs_id    = bus.cdb_rs_id;
        e.reg_addr = bus.cdb_reg_addr;
        e.result   = bus.cdb_result;
        e.cr0_xer  = bus.cdb_cr0_xer;
        return e;
    endfunction

    // Advance the reference model across one clock edge using the inputs now applied.
    task automatic tick();
        int g;
        bit free;
        g    = model_grant();
        free = !m_valid || cdb_ready_v;
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            sb.delete();
        end else begin
            if (m_valid && cdb_ready_v) void'(sb.pop_front());
            if (free) begin
                if (g >= 0) begin
                    sb.push_back(model_capture(g));
                    m_valid = 1'b1;
                    m_ptr   = (g + 1) % N;
                    if (one_shot) req[g] = 1'b0;
                    else unit_data[g] = rand_entry();
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        req         = '0;
        one_shot    = 1'b0;
        cdb_ready_v = 1'b1;
        drive();
        tick();
        tick();
        rst = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        req         = '1;
        xer_so_v    = 1'b0;
        cdb_ready_v = 1'b1;
        one_shot    = 1'b0;
        for (int i = 0; i < N; i++) unit_data[i] = rand_entry();
        drive();
        tick();
        @(negedge clk);
        checks++;
        if (bus.unit_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0000", bus.unit_ready);
        end
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus.cdb_valid);
        end
        checks++;
        if (observed() !== cdb_entry_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_fields: got %h expected 0", observed());
        end
        tick();
        rst = 1'b0;
        req = '0;
        drive();
    endtask

    task automatic test_single();
        unit_data[2]         = '0;
        unit_data[2].rs_id   = 5'd3;
        unit_data[2].reg_addr = 5'd7;
        unit_data[2].result  = 32'h0000_00FF;
        req                  = '0;
        req[2]               = 1'b1;
        one_shot             = 1'b1;
        cdb_ready_v          = 1'b1;
        drive();
        @(negedge clk);
        checks++;
        if (bus.unit_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_ready: got %b expected 0010", bus.unit_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rs_id !== 5'd3 || bus.cdb_reg_addr !== 5'd7 ||
            bus.cdb_result !== 32'h0000_00FF) begin
            errors++;
            $display("[TB] FAIL single_cdb: got v=%b id=%0d reg=%0d res=%h expected v=1 id=3 reg=7 res=000000ff",
                     bus.cdb_valid, bus.cdb_rs_id, bus.cdb_reg_addr, bus.cdb_result);
        end
        checks++;
        if (observed() !== sb[0]) begin
            errors++;
            $display("[TB] FAIL single_sb: got %h expected %h", observed(), sb[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain: got %b expected 0", bus.cdb_valid);
        end
        one_shot = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [0:N-1] oh;
        reset_dut();
        for (int i = 0; i < N; i++) unit_data[i] = rand_entry();
        req         = '1;
        cdb_ready_v = 1'b1;
        drive();
        for (int c = 0; c < 12; c++) begin
            oh        = '0;
            oh[c % N] = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.unit_ready !== oh) begin
                errors++;
                $display("[TB] FAIL rr_order c=%0d: got %b expected %b", c, bus.unit_ready, oh);
            end
            checks++;
            if (bus.cdb_valid !== (c > 0)) begin
                errors++;
                $display("[TB] FAIL rr_valid c=%0d: got %b expected %b", c, bus.cdb_valid, c > 0);
            end
            if (c > 0) begin
                checks++;
                if (observed() !== sb[0]) begin
                    errors++;
                    $display("[TB] FAIL rr_data c=%0d: got %h expected %h", c, observed(), sb[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back_stall();
        cdb_entry_t snap;
        snap        = sb[0];
        cdb_ready_v = 1'b0;
        drive();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.unit_ready !== 4'b0000 || bus.cdb_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hs c=%0d: got ready=%b v=%b expected ready=0000 v=1",
                         c, bus.unit_ready, bus.cdb_valid);
            end
            checks++;
            if (observed() !== snap) begin
                errors++;
                $display("[TB] FAIL stall_hold c=%0d: got %h expected %h", c, observed(), snap);
            end
            tick();
        end
        cdb_ready_v = 1'b1;
        drive();
        @(negedge clk);
        checks++;
        if (bus.unit_ready !== model_ready() || bus.unit_ready === 4'b0000) begin
            errors++;
            $display("[TB] FAIL release_grant: got %b expected %b", bus.unit_ready, model_ready());
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.cdb_valid !== 1'b1 || observed() !== sb[0]) begin
            errors++;
            $display("[TB] FAIL release_next: got v=%b %h expected v=1 %h", bus.cdb_valid, observed(), sb[0]);
        end
        tick();
    endtask

    task automatic test_skip_idle();
        reset_dut();
        one_shot     = 1'b1;
        unit_data[1] = rand_entry();
        req          = 4'b0100;
        drive();
        @(negedge clk);
        checks++;
        if (bus.unit_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL skip_setup: got %b expected 0100", bus.unit_ready);
        end
        tick();
        unit_data[1] = rand_entry();
        unit_data[3] = rand_entry();
        req          = 4'b0101;
        drive();
        @(negedge clk);
        checks++;
        if (bus.unit_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL skip_first: got %b expected 0001", bus.unit_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.unit_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL skip_second: got %b expected 0100", bus.unit_ready);
        end
        checks++;
        if (observed() !== sb[0]) begin
            errors++;
            $display("[TB] FAIL skip_data: got %h expected %h", observed(), sb[0]);
        end
        tick();
        req = '1;
        drive();
        @(negedge clk);
        checks++;
        if (bus.unit_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL skip_ptr: got %b expected 0010", bus.unit_ready);
        end
        req = '0;
        drive();
        tick();
        tick();
        one_shot = 1'b0;
    endtask

    task automatic test_cr0();
        reset_dut();
        one_shot                      = 1'b1;
        unit_data[0]                  = '0;
        unit_data[0].rs_id            = 5'd1;
        unit_data[0].reg_addr         = 5'd2;
        unit_data[0].result           = 32'h8000_0000;
        unit_data[0].cr0_xer          = '0;
        unit_data[0].cr0_xer.cr0_valid = 1'b1;
        unit_data[0].cr0_xer.cr0_gt   = 1'b1;
        unit_data[0].cr0_xer.cr0_eq   = 1'b1;
        unit_data[0].cr0_xer.xer_valid = 1'b1;
        unit_data[0].cr0_xer.xer_ov   = 1'b1;
        xer_so_v                      = 1'b1;
        req                           = 4'b1000;
        drive();
        tick();
        xer_so_v = 1'b0;
        drive();
        @(negedge clk);
`ifdef RESULT_ARB_CR0_CALC_EN
        checks++;
        if (bus.cdb_cr0_xer !== 9'b1_1001_1010) begin
            errors++;
            $display("[TB] FAIL cr0_neg: got %b expected 110011010", bus.cdb_cr0_xer);
        end
`else
        checks++;
        if (bus.cdb_cr0_xer !== 9'b1_0110_1010) begin
            errors++;
            $display("[TB] FAIL cr0_pass: got %b expected 101101010", bus.cdb_cr0_xer);
        end
`endif
        checks++;
        if (observed() !== sb[0]) begin
            errors++;
            $display("[TB] FAIL cr0_neg_sb: got %h expected %h", observed(), sb[0]);
        end
        unit_data[1]                   = '0;
        unit_data[1].result            = 32'h0;
        unit_data[1].cr0_xer.cr0_valid = 1'b1;
        unit_data[1].cr0_xer.cr0_lt    = 1'b1;
        unit_data[2]                   = '0;
        unit_data[2].result            = 32'h0000_0005;
        unit_data[2].cr0_xer           = 9'b0_1111_0000;
        xer_so_v                       = 1'b1;
        req                            = 4'b0110;
        drive();
        tick();
        @(negedge clk);
`ifdef RESULT_ARB_CR0_CALC_EN
        checks++;
        if (bus.cdb_cr0_xer !== 9'b1_0011_0000) begin
            errors++;
            $display("[TB] FAIL cr0_zero: got %b expected 100110000", bus.cdb_cr0_xer);
        end
`endif
        checks++;
        if (observed() !== sb[0]) begin
            errors++;
            $display("[TB] FAIL cr0_zero_sb: got %h expected %h", observed(), sb[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (observed() !== sb[0]) begin
            errors++;
            $display("[TB] FAIL cr0_novalid_sb: got %h expected %h", observed(), sb[0]);
        end
        tick();
        one_shot = 1'b0;
        xer_so_v = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < N; i++) unit_data[i] = rand_entry();
        req         = '1;
        cdb_ready_v = 1'b0;
        drive();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (bus.cdb_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_held: got %b expected 1", bus.cdb_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.unit_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midrst_ready: got %b expected 0000", bus.unit_ready);
        end
        tick();
        rst = 1'b0;
        drive();
        @(negedge clk);
        checks++;
        if (bus.cdb_valid !== 1'b0 || bus.unit_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL midrst_after: got v=%b ready=%b expected v=0 ready=1000",
                     bus.cdb_valid, bus.unit_ready);
        end
        req = '0;
        drive();
        tick();
    endtask

    initial begin
        req         = '0;
        xer_so_v    = 1'b0;
        cdb_ready_v = 1'b1;
        one_shot    = 1'b0;
        m_ptr       = 0;
        m_valid     = 1'b0;
        for (int i = 0; i < N; i++) unit_data[i] = '0;
        drive();
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_stall();
        test_skip_idle();
        test_cr0();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
